// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate op codes, occupancy states and the single-lane immediate expansion function
//   IMM_GEN_ZICSR_EN defined: op 6 gives the CSR zimm and op 7 gives shamt; otherwise both give 0
package imm_gen_pkg;
  localparam int IMM_OP_W = 3;
  localparam logic [IMM_OP_W-1:0] IMM_R     = 3'd0;
  localparam logic [IMM_OP_W-1:0] IMM_I     = 3'd1;
  localparam logic [IMM_OP_W-1:0] IMM_S     = 3'd2;
  localparam logic [IMM_OP_W-1:0] IMM_SB    = 3'd3;
  localparam logic [IMM_OP_W-1:0] IMM_J     = 3'd4;
  localparam logic [IMM_OP_W-1:0] IMM_U     = 3'd5;
  localparam logic [IMM_OP_W-1:0] IMM_CSR   = 3'd6;
  localparam logic [IMM_OP_W-1:0] IMM_SHAMT = 3'd7;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_MAIN, OCC_SKID} occ_e;
  // 32-bit RV immediate; bit 31 is the sign for every format, so callers widen with a sign cast
  function automatic logic [31:0] expand_imm(input logic [31:0] inst, input logic [IMM_OP_W-1:0] op);
    logic [31:0] imm;
    imm = '0;
    case (op)
      IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_SB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:     imm = {inst[31:12], 12'b0};
`ifdef IMM_GEN_ZICSR_EN
      IMM_CSR:   imm = {27'b0, inst[19:15]};
      IMM_SHAMT: imm = {27'b0, inst[24:20]};
`endif
      default:   imm = '0;
    endcase
    return imm;
  endfunction
endpackage

// File: rtl/imm_expand.sv
// imm_expand: combinational single-lane immediate expander
//   inst   in  XLEN      instruction word
//   imm_op in  IMM_OP_W  immediate type code
//   imm    out XLEN      expanded immediate
//   IMM_GEN_ZICSR_EN (via imm_gen_pkg) enables ops 6/7
module imm_expand
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]     inst,
  input  logic [IMM_OP_W-1:0] imm_op,
  output logic [XLEN-1:0]     imm
);
  logic [31:0] raw;
  assign raw = expand_imm(inst[31:0], imm_op);
  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered multi-lane immediate/target generation with a one-entry skid buffer
//   clk, rst_n (sync active-low), flush
//   in_valid/in_ready, in_lane_vld[LANES], in_pc/in_inst[LANES*XLEN], in_imm_op[LANES*3]
//   out_valid/out_ready, out_lane_vld[LANES], out_imm/out_target[LANES*XLEN]
//   IMM_GEN_ZICSR_EN defined: ops 6/7 produce CSR zimm / shamt
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_vld,
  input  logic [LANES*XLEN-1:0]     in_pc,
  input  logic [LANES*XLEN-1:0]     in_inst,
  input  logic [LANES*IMM_OP_W-1:0] in_imm_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_vld,
  output logic [LANES*XLEN-1:0]     out_imm,
  output logic [LANES*XLEN-1:0]     out_target
);
  occ_e state, state_nxt;
  logic accept, load_main_in, load_main_skid, load_skid;
  logic [LANES*XLEN-1:0] nxt_imm, nxt_target, skid_imm, skid_target;
  logic [LANES-1:0] skid_lane_vld;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [XLEN-1:0] lane_imm;
    imm_expand #(.XLEN(XLEN)) u_expand (
      .inst   (in_inst[g*XLEN +: XLEN]),
      .imm_op (in_imm_op[g*IMM_OP_W +: IMM_OP_W]),
      .imm    (lane_imm)
    );
    assign nxt_imm[g*XLEN +: XLEN]    = in_lane_vld[g] ? lane_imm : '0;
    assign nxt_target[g*XLEN +: XLEN] = in_lane_vld[g] ? in_pc[g*XLEN +: XLEN] + lane_imm : '0;
  end
  always_ff @(posedge clk) state <= !rst_n ? OCC_EMPTY : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      OCC_EMPTY: state_nxt = accept ? OCC_MAIN : OCC_EMPTY;
      OCC_MAIN:  state_nxt = accept ? (out_ready ? OCC_MAIN : OCC_SKID) : (out_ready ? OCC_EMPTY : OCC_MAIN);
      OCC_SKID:  state_nxt = out_ready ? OCC_MAIN : OCC_SKID;
      default:   state_nxt = OCC_EMPTY;
    endcase
    if (flush) state_nxt = OCC_EMPTY;
  end
  // in_ready depends only on the state register, so it never combinationally follows out_ready
  always_comb begin
    in_ready       = state != OCC_SKID;
    out_valid      = state != OCC_EMPTY;
    accept         = in_valid & in_ready & ~flush;
    load_main_in   = accept & ((state == OCC_EMPTY) | ((state == OCC_MAIN) & out_ready));
    load_skid      = accept & (state == OCC_MAIN) & ~out_ready;
    load_main_skid = ~flush & (state == OCC_SKID) & out_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_lane_vld  <= '0;
      out_imm       <= '0;
      out_target    <= '0;
      skid_lane_vld <= '0;
      skid_imm      <= '0;
      skid_target   <= '0;
    end else begin
      if (load_main_in) begin
        out_lane_vld <= in_lane_vld;
        out_imm      <= nxt_imm;
        out_target   <= nxt_target;
      end else if (load_main_skid) begin
        out_lane_vld <= skid_lane_vld;
        out_imm      <= skid_imm;
        out_target   <= skid_target;
      end
      if (load_skid) begin
        skid_lane_vld <= in_lane_vld;
        skid_imm      <= nxt_imm;
        skid_target   <= nxt_target;
      end
    end
  end
endmodule
